// File: rtl/eth_frame_parser_qinq_pkg.sv
// Shared types and constants for the QinQ-aware Ethernet frame parser.
//   eth_meta_v2_t : per-frame metadata record pushed into the metadata FIFO
//   TPID_* / ETH_*: EtherType constants used by the tag walker and classifier
//   PROTO_*       : one-hot protocol codes carried in proto_onehot
package eth_frame_parser_qinq_pkg;

  localparam logic [15:0] TPID_8021Q  = 16'h8100;
  localparam logic [15:0] TPID_8021AD = 16'h88A8;
  localparam logic [15:0] ETH_IPV4    = 16'h0800;
  localparam logic [15:0] ETH_IPV6    = 16'h86DD;
  localparam logic [15:0] ETH_ARP     = 16'h0806;

  localparam logic [3:0] PROTO_IPV4    = 4'b0001;
  localparam logic [3:0] PROTO_IPV6    = 4'b0010;
  localparam logic [3:0] PROTO_ARP     = 4'b0100;
  localparam logic [3:0] PROTO_UNKNOWN = 4'b1000;

  typedef struct packed {
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic [1:0]  vlan_count;
    logic [11:0] outer_vid;
    logic [11:0] inner_vid;
    logic [4:0]  l2_hdr_len;
    logic [3:0]  proto_onehot;
    logic        err_runt;
    logic        err_vlan_overflow;
    logic [15:0] frame_beats;
  } eth_meta_v2_t;

  function automatic logic is_tpid(input logic [15:0] t);
    return (t == TPID_8021Q) || (t == TPID_8021AD);
  endfunction

  function automatic logic [3:0] classify(input logic [15:0] et);
    case (et)
      ETH_IPV4: return PROTO_IPV4;
      ETH_IPV6: return PROTO_IPV6;
      ETH_ARP:  return PROTO_ARP;
      default:  return PROTO_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/eth_meta_fifo.sv
// Synchronous FIFO holding per-frame metadata records.
//   clk, rst      : clock, asynchronous active-high reset (empties the FIFO)
//   din, push     : write port; a push while full is dropped
//   pop           : removes the head entry; a pop while empty is ignored
//   dout          : head entry (show-ahead, valid whenever !empty)
//   full, empty   : occupancy flags
module eth_meta_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/eth_frame_parser_qinq.sv
// Ethernet frame parser with stacked 802.1Q / 802.1ad tag support.
// Frames pass through one registered AXI4-Stream stage; header bytes are
// captured as they stream by, and on the tlast beat the captured bytes are
// merged with that beat, parsed, and pushed as one eth_meta_v2_t record into
// a metadata FIFO.
//   clk, rst                 : clock, asynchronous active-high reset
//   s_axis_*                 : ingress stream (byte n of a beat in lane n)
//   m_axis_*                 : egress stream, one-cycle registered copy
//   m_meta, m_meta_valid/ready : metadata FIFO head and pop handshake
module eth_frame_parser_qinq
  import eth_frame_parser_qinq_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int MAX_VLAN_TAGS = 2,
  parameter int META_DEPTH    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [$bits(eth_meta_v2_t)-1:0]  m_meta,
  output logic                             m_meta_valid,
  input  logic                             m_meta_ready
);
  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int HDR_BYTES = 14 + 4 * MAX_VLAN_TAGS;
  localparam int MW        = $bits(eth_meta_v2_t);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t       state;
  logic [7:0]   byte_cnt;   // header bytes seen so far, saturates at HDR_BYTES
  logic [7:0]   cnt_sum;    // bytes available including the current beat
  logic [7:0]   cnt_nxt;
  logic [15:0]  beat_cnt;   // beats accepted before the current one
  logic [7:0]   hdr [HDR_BYTES];
  logic [7:0]   mrg [HDR_BYTES];
  logic         acc, push, meta_full, meta_empty;
  eth_meta_v2_t meta_nxt;

  // Only the tlast beat needs a FIFO slot, so only it waits on a full FIFO.
  assign s_axis_tready = (~m_axis_tvalid | m_axis_tready) & ~(meta_full & s_axis_tlast);
  assign acc           = s_axis_tvalid & s_axis_tready;
  assign push          = acc & s_axis_tlast;
  assign cnt_sum       = byte_cnt + 8'(BYTES);
  assign cnt_nxt       = (cnt_sum >= 8'(HDR_BYTES)) ? 8'(HDR_BYTES) : cnt_sum;

  function automatic logic [7:0] lane(input logic [DATA_WIDTH-1:0] d, input int n);
    logic [DATA_WIDTH-1:0] s;
    s = d >> (8 * n);
    return s[7:0];
  endfunction

  // Header view: captured bytes, then bytes of the current beat, then zeros
  // for anything not yet received.
  always_comb begin
    for (int i = 0; i < HDR_BYTES; i++) begin
      if (8'(i) < byte_cnt)     mrg[i] = hdr[i];
      else if (8'(i) < cnt_sum) mrg[i] = lane(s_axis_tdata, i - int'(byte_cnt));
      else                      mrg[i] = 8'h00;
    end
  end

  // Tag walker. A tag only counts once all four of its bytes plus the
  // following type field are present; a TPID seen without them is a runt.
  always_comb begin
    logic [15:0] t;
    logic [1:0]  vc;
    logic        runt;
    logic        stop;
    logic [11:0] vid [2];
    meta_nxt = '0;
    vid[0]   = '0;
    vid[1]   = '0;
    t        = {mrg[12], mrg[13]};
    vc       = '0;
    runt     = (cnt_sum < 8'd14);
    stop     = runt;
    for (int k = 0; k < MAX_VLAN_TAGS; k++) begin
      if (!stop && is_tpid(t)) begin
        if (cnt_sum < 8'(18 + 4 * k)) begin
          runt = 1'b1;
          stop = 1'b1;
        end else begin
          vid[k] = {mrg[14 + 4 * k][3:0], mrg[15 + 4 * k]};
          t      = {mrg[16 + 4 * k], mrg[17 + 4 * k]};
          vc     = vc + 2'd1;
        end
      end else begin
        stop = 1'b1;
      end
    end
    meta_nxt.dest_mac          = {mrg[0], mrg[1], mrg[2], mrg[3], mrg[4], mrg[5]};
    meta_nxt.src_mac           = {mrg[6], mrg[7], mrg[8], mrg[9], mrg[10], mrg[11]};
    meta_nxt.ethertype         = runt ? 16'h0000 : t;
    meta_nxt.vlan_count        = vc;
    meta_nxt.outer_vid         = vid[0];
    meta_nxt.inner_vid         = vid[1];
    meta_nxt.l2_hdr_len        = 5'd14 + {1'b0, vc, 2'b00};
    meta_nxt.proto_onehot      = runt ? PROTO_UNKNOWN : classify(t);
    meta_nxt.err_runt          = runt;
    meta_nxt.err_vlan_overflow = ~runt & is_tpid(t);
    meta_nxt.frame_beats       = (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;
  end

  // Frame tracking. The state is a function of byte_cnt, so wide beats that
  // cover the whole header go straight to PAYLOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      beat_cnt <= '0;
      for (int i = 0; i < HDR_BYTES; i++) hdr[i] <= '0;
    end else if (acc) begin
      if (state != PAYLOAD)
        for (int i = 0; i < HDR_BYTES; i++) hdr[i] <= mrg[i];
      if (s_axis_tlast) begin
        state    <= IDLE;
        byte_cnt <= '0;
        beat_cnt <= '0;
      end else begin
        state    <= (cnt_nxt == 8'(HDR_BYTES)) ? PAYLOAD : HEADER;
        byte_cnt <= cnt_nxt;
        beat_cnt <= (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;
      end
    end
  end

  // Output register: loads whenever it is empty or being drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (!m_axis_tvalid || m_axis_tready) begin
      m_axis_tvalid <= acc;
      if (acc) begin
        m_axis_tdata <= s_axis_tdata;
        m_axis_tlast <= s_axis_tlast;
      end
    end
  end

  eth_meta_fifo #(
    .WIDTH (MW),
    .DEPTH (META_DEPTH)
  ) u_meta_fifo (
    .clk   (clk),
    .rst   (rst),
    .din   (meta_nxt),
    .push  (push),
    .pop   (m_meta_ready),
    .dout  (m_meta),
    .full  (meta_full),
    .empty (meta_empty)
  );

  assign m_meta_valid = ~meta_empty;

endmodule

// File: tb/tb_eth_frame_parser_qinq.sv
`timescale 1ns/1ps
module tb_eth_frame_parser_qinq;
  import eth_frame_parser_qinq_pkg::*;

  localparam int DW = 64;
  localparam int MW = $bits(eth_meta_v2_t);
  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [MW-1:0] m_meta;
  logic          m_meta_valid, m_meta_ready;
  logic          s1_tready, m1_tvalid, m1_tlast, m1_meta_valid;
  logic [DW-1:0] m1_tdata;
  logic [MW-1:0] m1_meta;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit rnd_en = 0;

  // Main instance: two tags, two-entry metadata FIFO.
  eth_frame_parser_qinq #(.DATA_WIDTH(DW), .MAX_VLAN_TAGS(2), .META_DEPTH(2)) u_dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .m_meta(m_meta), .m_meta_valid(m_meta_valid), .m_meta_ready(m_meta_ready));

  // Single-tag instance fed the same stream.
  eth_frame_parser_qinq #(.DATA_WIDTH(DW), .MAX_VLAN_TAGS(1), .META_DEPTH(2)) u_dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s1_tready),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m1_tdata), .m_axis_tvalid(m1_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m1_tlast),
    .m_meta(m1_meta), .m_meta_valid(m1_meta_valid), .m_meta_ready(m_meta_ready));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  logic [DW:0]  got_q[$], exp_q[$];
  int           got_cyc[$], in_cyc[$];
  eth_meta_v2_t meta_q[$], meta1_q[$];
  logic         prev_mv = 1'b0, tl_mv = 1'b0, tl_prev = 1'b1;
  int           lockstep_err = 0;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back({m_axis_tlast, m_axis_tdata});
        got_cyc.push_back(cyc);
        if (m_axis_tlast) begin
          tl_mv   = m_meta_valid;
          tl_prev = prev_mv;
        end
      end
      if (m_meta_valid && m_meta_ready) meta_q.push_back(eth_meta_v2_t'(m_meta));
      if (m1_meta_valid && m_meta_ready) meta1_q.push_back(eth_meta_v2_t'(m1_meta));
      if ({s1_tready, m1_tvalid, m1_tlast, m1_tdata} !==
          {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata}) lockstep_err++;
    end
    prev_mv = m_meta_valid;
  end

  task automatic clear_q();
    got_q.delete(); exp_q.delete(); got_cyc.delete(); in_cyc.delete();
    meta_q.delete(); meta1_q.delete();
    tl_mv = 1'b0; tl_prev = 1'b1;
  endtask

  // dst 00:11:22:33:44:55, src 66:77:88:99:AA:BB, nw big-endian words, payload A0+idx.
  function automatic bq_t mk_frame(input logic [95:0] w, input int nw, input int total);
    bq_t b;
    logic [47:0] dst;
    logic [47:0] src;
    dst = 48'h001122334455;
    src = 48'h66778899AABB;
    for (int i = 0; i < 6; i++) b.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) b.push_back(src[47-8*i -: 8]);
    for (int i = 0; i < nw; i++) begin
      b.push_back(w[95-16*i -: 8]);
      b.push_back(w[87-16*i -: 8]);
    end
    while (b.size() < total) b.push_back(8'hA0 + 8'(b.size()));
    while (b.size() > total) void'(b.pop_back());
    return b;
  endfunction

  task automatic drive_beat(input logic [DW-1:0] d, input logic last);
    int n;
    bit ok;
    s_axis_tdata = d; s_axis_tvalid = 1'b1; s_axis_tlast = last;
    n = 0; ok = 0;
    while (!ok && n < 500) begin
      @(negedge clk);
      if (s_axis_tready) begin
        ok = 1;
        exp_q.push_back({last, d});
        in_cyc.push_back(cyc);
      end
      n++;
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL drive_timeout: beat not accepted within %0d cycles", n);
    end
  endtask

  task automatic send_frame(input bq_t b);
    int nb;
    logic [DW-1:0] d;
    nb = (b.size() + 7) / 8;
    for (int i = 0; i < nb; i++) begin
      d = '0;
      for (int n = 0; n < 8; n++) if (8*i + n < b.size()) d[8*n +: 8] = b[8*i + n];
      drive_beat(d, 1'(i == nb - 1));
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got=%b exp=0", m_axis_tlast); end
    checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL rst_tdata got=%h exp=0", m_axis_tdata); end
    checks++; if (m_meta_valid !== 1'b0) begin errors++; $display("FAIL rst_meta_valid got=%b exp=0", m_meta_valid); end
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rst_tready got=%b exp=1", s_axis_tready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_untagged_ipv4();
    bq_t b;
    eth_meta_v2_t m;
    int nbad;
    clear_q();
    b = mk_frame({16'h0800, 80'h0}, 1, 64);
    send_frame(b);
    repeat (4) @(posedge clk); #1;
    nbad = 0;
    foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) nbad++;
    checks++; if (got_q.size() != 8 || exp_q.size() != 8 || nbad != 0) begin errors++;
      $display("FAIL ipv4_stream got_beats=%0d exp_beats=8 bad=%0d", got_q.size(), nbad); end
    checks++; if (got_cyc.size() != 8 || got_cyc[0] != in_cyc[0] + 1) begin errors++;
      $display("FAIL ipv4_latency got_out_cycles=%0d exp=1 latency", got_cyc.size()); end
    checks++; if (got_cyc.size() != 8 || got_cyc[7] != got_cyc[0] + 7) begin errors++;
      $display("FAIL ipv4_no_bubble got_beats=%0d exp=8 contiguous", got_cyc.size()); end
    checks++; if (tl_mv !== 1'b1 || tl_prev !== 1'b0) begin errors++;
      $display("FAIL ipv4_meta_timing got=%b%b exp=01 (prev,at_tlast)", tl_prev, tl_mv); end
    checks++; if (meta_q.size() != 1) begin errors++; $display("FAIL ipv4_meta_count got=%0d exp=1", meta_q.size()); end
    m = (meta_q.size() > 0) ? meta_q[0] : '0;
    checks++; if (m.ethertype !== 16'h0800) begin errors++; $display("FAIL ipv4_ethertype got=%h exp=0800", m.ethertype); end
    checks++; if (m.vlan_count !== 2'd0) begin errors++; $display("FAIL ipv4_vlan_count got=%0d exp=0", m.vlan_count); end
    checks++; if (m.l2_hdr_len !== 5'd14) begin errors++; $display("FAIL ipv4_l2_len got=%0d exp=14", m.l2_hdr_len); end
    checks++; if (m.proto_onehot !== PROTO_IPV4) begin errors++; $display("FAIL ipv4_proto got=%b exp=%b", m.proto_onehot, PROTO_IPV4); end
    checks++; if (m.frame_beats !== 16'd8) begin errors++; $display("FAIL ipv4_beats got=%0d exp=8", m.frame_beats); end
    checks++; if (m.dest_mac !== 48'h001122334455 || m.src_mac !== 48'h66778899AABB) begin errors++;
      $display("FAIL ipv4_macs got=%h/%h exp=001122334455/66778899aabb", m.dest_mac, m.src_mac); end
    checks++; if (m.err_runt !== 1'b0 || m.err_vlan_overflow !== 1'b0) begin errors++;
      $display("FAIL ipv4_errs got=%b%b exp=00", m.err_runt, m.err_vlan_overflow); end
  endtask

  task automatic test_qinq();
    eth_meta_v2_t m;
    clear_q();
    send_frame(mk_frame({16'h88A8, 16'h0123, 16'h8100, 16'h0456, 16'h86DD, 16'h0}, 5, 40));
    repeat (4) @(posedge clk); #1;
    checks++; if (meta_q.size() != 1) begin errors++; $display("FAIL qinq_meta_count got=%0d exp=1", meta_q.size()); end
    m = (meta_q.size() > 0) ? meta_q[0] : '0;
    checks++; if (m.vlan_count !== 2'd2) begin errors++; $display("FAIL qinq_vlan_count got=%0d exp=2", m.vlan_count); end
    checks++; if (m.outer_vid !== 12'h123 || m.inner_vid !== 12'h456) begin errors++;
      $display("FAIL qinq_vids got=%h/%h exp=123/456", m.outer_vid, m.inner_vid); end
    checks++; if (m.l2_hdr_len !== 5'd22) begin errors++; $display("FAIL qinq_l2_len got=%0d exp=22", m.l2_hdr_len); end
    checks++; if (m.proto_onehot !== PROTO_IPV6 || m.ethertype !== 16'h86DD) begin errors++;
      $display("FAIL qinq_proto got=%b/%h exp=%b/86dd", m.proto_onehot, m.ethertype, PROTO_IPV6); end
    checks++; if (m.frame_beats !== 16'd5 || m.err_vlan_overflow !== 1'b0 || m.err_runt !== 1'b0) begin errors++;
      $display("FAIL qinq_beats_errs got=%0d,%b%b exp=5,00", m.frame_beats, m.err_runt, m.err_vlan_overflow); end
  endtask

  task automatic test_vlan_overflow();
    eth_meta_v2_t m;
    clear_q();
    send_frame(mk_frame({16'h88A8, 16'h0123, 16'h8100, 16'h0456, 16'h0800, 16'h0}, 5, 40));
    repeat (4) @(posedge clk); #1;
    checks++; if (meta1_q.size() != 1) begin errors++; $display("FAIL ovf_meta_count got=%0d exp=1", meta1_q.size()); end
    m = (meta1_q.size() > 0) ? meta1_q[0] : '0;
    checks++; if (m.vlan_count !== 2'd1 || m.outer_vid !== 12'h123 || m.inner_vid !== 12'h000) begin errors++;
      $display("FAIL ovf_tags got=%0d,%h,%h exp=1,123,000", m.vlan_count, m.outer_vid, m.inner_vid); end
    checks++; if (m.err_vlan_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", m.err_vlan_overflow); end
    checks++; if (m.ethertype !== 16'h8100 || m.proto_onehot !== PROTO_UNKNOWN) begin errors++;
      $display("FAIL ovf_type got=%h/%b exp=8100/%b", m.ethertype, m.proto_onehot, PROTO_UNKNOWN); end
    checks++; if (m.l2_hdr_len !== 5'd18) begin errors++; $display("FAIL ovf_l2_len got=%0d exp=18", m.l2_hdr_len); end
  endtask

  task automatic test_runt();
    eth_meta_v2_t m;
    clear_q();
    send_frame(mk_frame(96'h0, 0, 8));                                   // one beat
    send_frame(mk_frame({16'h8100, 16'h0ABC, 64'h0}, 2, 16));             // tag cut short
    send_frame(mk_frame({16'h88A8, 16'h0123, 16'h8100, 16'h0456, 16'h0800, 16'h0}, 5, 24)); // just enough
    repeat (4) @(posedge clk); #1;
    checks++; if (meta_q.size() != 3) begin errors++; $display("FAIL runt_meta_count got=%0d exp=3", meta_q.size()); end
    m = (meta_q.size() > 0) ? meta_q[0] : '0;
    checks++; if (m.err_runt !== 1'b1 || m.frame_beats !== 16'd1) begin errors++;
      $display("FAIL runt1_flag_beats got=%b,%0d exp=1,1", m.err_runt, m.frame_beats); end
    checks++; if (m.ethertype !== 16'h0000 || m.proto_onehot !== PROTO_UNKNOWN) begin errors++;
      $display("FAIL runt1_type got=%h/%b exp=0000/%b", m.ethertype, m.proto_onehot, PROTO_UNKNOWN); end
    m = (meta_q.size() > 1) ? meta_q[1] : '0;
    checks++; if (m.err_runt !== 1'b1 || m.vlan_count !== 2'd0 || m.frame_beats !== 16'd2) begin errors++;
      $display("FAIL runt2_tag got=%b,%0d,%0d exp=1,0,2", m.err_runt, m.vlan_count, m.frame_beats); end
    m = (meta_q.size() > 2) ? meta_q[2] : '0;
    checks++; if (m.err_runt !== 1'b0 || m.vlan_count !== 2'd2 || m.proto_onehot !== PROTO_IPV4) begin errors++;
      $display("FAIL full24 got=%b,%0d,%b exp=0,2,%b", m.err_runt, m.vlan_count, m.proto_onehot, PROTO_IPV4); end
  endtask

  task automatic test_back_to_back();
    eth_meta_v2_t m;
    clear_q();
    send_frame(mk_frame({16'h0806, 80'h0}, 1, 24));
    send_frame(mk_frame({16'h8100, 16'h0FFF, 16'h86DD, 48'h0}, 3, 24));
    repeat (4) @(posedge clk); #1;
    checks++; if (got_cyc.size() != 6 || got_cyc[5] != got_cyc[0] + 5) begin errors++;
      $display("FAIL b2b_no_bubble got_beats=%0d exp=6 contiguous", got_cyc.size()); end
    checks++; if (meta_q.size() != 2) begin errors++; $display("FAIL b2b_meta_count got=%0d exp=2", meta_q.size()); end
    m = (meta_q.size() > 0) ? meta_q[0] : '0;
    checks++; if (m.proto_onehot !== PROTO_ARP || m.frame_beats !== 16'd3 || m.vlan_count !== 2'd0) begin errors++;
      $display("FAIL b2b_f1 got=%b,%0d,%0d exp=%b,3,0", m.proto_onehot, m.frame_beats, m.vlan_count, PROTO_ARP); end
    m = (meta_q.size() > 1) ? meta_q[1] : '0;
    checks++; if (m.vlan_count !== 2'd1 || m.outer_vid !== 12'hFFF || m.proto_onehot !== PROTO_IPV6 || m.l2_hdr_len !== 5'd18) begin errors++;
      $display("FAIL b2b_f2 got=%0d,%h,%b,%0d exp=1,fff,%b,18", m.vlan_count, m.outer_vid, m.proto_onehot, m.l2_hdr_len, PROTO_IPV6); end
  endtask

  task automatic test_backpressure();
    bq_t b;
    int stall, n, pops_before, nbad, nbeat;
    clear_q();
    b = mk_frame({16'h0806, 80'h0}, 1, 16);
    m_meta_ready = 1'b0;
    rnd_en = 1;
    stall = 0; n = 0; pops_before = -1;
    fork
      begin
        send_frame(b); send_frame(b); send_frame(b);
      end
      begin
        while (stall < 4 && n < 400) begin
          @(negedge clk); n++;
          if (s_axis_tvalid && s_axis_tlast && !s_axis_tready && (!m_axis_tvalid || m_axis_tready)) stall++;
        end
        pops_before = meta_q.size();
        @(posedge clk); #1; m_meta_ready = 1'b1;
        @(posedge clk); #1; m_meta_ready = 1'b0;
      end
    join
    rnd_en = 0;
    @(posedge clk); #2;
    m_axis_tready = 1'b1;
    m_meta_ready = 1'b1;
    repeat (6) @(posedge clk); #1;
    checks++; if (stall < 4) begin errors++; $display("FAIL bp_stall got=%0d exp>=4 stall cycles", stall); end
    checks++; if (pops_before != 0) begin errors++; $display("FAIL bp_pops_before got=%0d exp=0", pops_before); end
    checks++; if (meta_q.size() != 3) begin errors++; $display("FAIL bp_meta_count got=%0d exp=3", meta_q.size()); end
    nbeat = 0;
    foreach (meta_q[i]) if (meta_q[i].frame_beats !== 16'd2 || meta_q[i].proto_onehot !== PROTO_ARP) nbeat++;
    checks++; if (nbeat != 0) begin errors++; $display("FAIL bp_meta_fields got=%0d bad exp=0 bad", nbeat); end
    nbad = 0;
    foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) nbad++;
    checks++; if (got_q.size() != 6 || exp_q.size() != 6 || nbad != 0) begin errors++;
      $display("FAIL bp_stream got_beats=%0d exp_beats=6 bad=%0d", got_q.size(), nbad); end
  endtask

  task automatic test_reset_mid_frame();
    bq_t b;
    logic [DW-1:0] d;
    eth_meta_v2_t m;
    clear_q();
    b = mk_frame({16'h0800, 80'h0}, 1, 64);
    for (int i = 0; i < 4; i++) begin
      d = '0;
      for (int n = 0; n < 8; n++) d[8*n +: 8] = b[8*i + n];
      drive_beat(d, 1'b0);
    end
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0) begin errors++;
      $display("FAIL midrst_clear got=%b/%h exp=0/0", m_axis_tvalid, m_axis_tdata); end
    checks++; if (m_meta_valid !== 1'b0) begin errors++; $display("FAIL midrst_meta_valid got=%b exp=0", m_meta_valid); end
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    clear_q();
    send_frame(mk_frame({16'h88A8, 16'h0123, 16'h8100, 16'h0456, 16'h86DD, 16'h0}, 5, 40));
    repeat (4) @(posedge clk); #1;
    checks++; if (meta_q.size() != 1) begin errors++; $display("FAIL midrst_meta_count got=%0d exp=1", meta_q.size()); end
    m = (meta_q.size() > 0) ? meta_q[0] : '0;
    checks++; if (m.vlan_count !== 2'd2 || m.outer_vid !== 12'h123 || m.frame_beats !== 16'd5 || m.proto_onehot !== PROTO_IPV6) begin errors++;
      $display("FAIL midrst_next got=%0d,%h,%0d,%b exp=2,123,5,%b", m.vlan_count, m.outer_vid, m.frame_beats, m.proto_onehot, PROTO_IPV6); end
  endtask

  initial begin
    rst = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1; m_meta_ready = 1'b1;
    test_reset();
    test_untagged_ipv4();
    test_qinq();
    test_vlan_overflow();
    test_runt();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    checks++; if (lockstep_err != 0) begin errors++;
      $display("FAIL lockstep_stream got=%0d diverging cycles exp=0", lockstep_err); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
